stream_demux_w_qos: RTL
=======================

# stream_demux_w_qos

Packet-aware 1-to-N stream router. It is the egress counterpart of the QoS stream arbiter: it takes the single merged stream (data, qos, id, last) and returns each packet to the output stream selected by its id. The destination and qos are locked for the whole packet. Packets with an out-of-range id are discarded. A one-entry output register gives one cycle of latency at full throughput.

## Interface
- T_DATA_WIDTH, 4, data width per beat
- T_QOS__WIDTH, 2, qos width
- STREAM_COUNT, 3, number of output streams
- T_ID___WIDTH, $clog2(STREAM_COUNT), id width
- clk  input  1  clock; all logic on posedge
- rst  input  1  reset, synchronous, active-high
- s_data_in  input  T_DATA_WIDTH  input beat data
- s_qos_in  input  T_QOS__WIDTH  packet qos; sampled on first beat only
- s_id_in  input  T_ID___WIDTH  destination; sampled on first beat only
- s_last_in  input  1  last beat of packet
- s_valid_in  input  1  input beat valid
- s_ready_out  output  1  input beat accepted when valid && ready
- m_data_out  output  [STREAM_COUNT] x T_DATA_WIDTH  per-output data (broadcast of the held beat)
- m_qos_out  output  [STREAM_COUNT] x T_QOS__WIDTH  per-output locked qos (broadcast)
- m_last_out  output  STREAM_COUNT  per-output last (broadcast)
- m_valid_out  output  STREAM_COUNT  one-hot; bit reg_dest set when the register is full
- m_ready_in  input  STREAM_COUNT  per-output ready
- drop_cnt_out  output  8  dropped-packet count; present only with STREAM_DEMUX_DROP_CNT_EN

## Operation
- **State machine.** States: IDLE (expects the first beat), FWD (mid-packet to a valid destination), DROP (mid-packet discard).
- **IDLE, first beat accepted:**
  - s_id_in < STREAM_COUNT: lock dest = s_id_in and qos = s_qos_in, then load the output register. Go to FWD if s_last_in = 0; stay in IDLE if it is 1.
  - s_id_in >= STREAM_COUNT: discard the beat and increment the drop count. Go to DROP if s_last_in = 0; stay in IDLE if it is 1.
- **FWD.** Every accepted beat loads the register with the locked dest and qos; s_id_in and s_qos_in are ignored. An accepted beat with last = 1 returns the FSM to IDLE.
- **DROP.** s_ready_out = 1 and beats are discarded. An accepted beat with last = 1 returns the FSM to IDLE.
- **Output register.** Holds {data, last, dest, qos} and a full flag.
  - It drains when m_ready_in[dest] = 1.
  - s_ready_out = !full || m_ready_in[dest], except in DROP, and in IDLE when s_id_in is invalid; in both of those cases it is 1.
  - Loading while draining gives back-to-back throughput.
- **Broadcast.** m_data_out, m_qos_out and m_last_out carry the same held values on every output. Only m_valid_out is qualified by dest.
- **Unused ready.** m_ready_in bits other than dest are ignored.
- **Zero qos.** qos = 0 is a legal value and passes through unchanged.

## Timing
- **Reset** (rst = 1 at a posedge):
  - state = IDLE, full = 0, all m_* outputs = 0, drop count = 0.
  - s_ready_out = 0 while rst is high.
- **Reset mid-packet:** the held beat is lost and the partial packet is abandoned. After reset the next accepted beat is treated as a first beat.
- **Latency:** a beat accepted at edge k appears on m_valid_out[dest] from edge k onward, i.e. valid in cycle k+1.
- **Throughput:** one beat per cycle while m_ready_in[dest] = 1.
- **Stall:** with m_ready_in[dest] = 0 and the register full:
  - s_ready_out = 0;
  - held data stays stable and m_valid_out stays asserted until accepted;
  - the FSM does not advance.
- **Last beat:** last and the next first beat may arrive on consecutive cycles with no bubble, including to a different dest. This holds because the held beat drains in the same cycle it is replaced.
- **Drop count:** increments on the edge that accepts the first beat of an invalid packet. Saturates at 255.

## Configuration
- **STREAM_DEMUX_DROP_CNT_EN defined:**
  - the 8-bit saturating drop counter and the drop_cnt_out port exist;
  - drop_cnt_out resets to 0.
- **Not defined:**
  - no counter and no port;
  - invalid-id packets are still discarded silently;
  - all other behaviour is identical.

## Test plan
- **Single-beat packet:** reset, then send id = 1, qos = 2, data = 0xA, last = 1 with m_ready_in = 3'b111.
  - Expect m_valid_out = 3'b010, m_data_out = 0xA, m_qos_out = 2, m_last_out = 1 in the next cycle.
  - Expect s_ready_out = 1 throughout.
- **Mid-packet lock:** 3-beat packet with id = 2, qos = 3, where beats 2–3 carry id = 0 and qos = 1.
  - Expect all 3 beats on output 2 with qos = 3, on consecutive cycles.
  - Expect last on beat 3 only.
- **Backpressure:** hold m_ready_in[0] = 0 for 4 cycles during a packet to output 0.
  - Expect s_ready_out = 0 and stable held data.
  - Expect no beat loss or duplication after release.
- **Invalid id:** send a 2-beat packet with id = 3, then a packet with id = 0, data = 0x5.
  - Expect the first packet consumed with no m_valid_out activity.
  - Expect drop_cnt_out = 1 (with the macro).
  - Expect 0x5 on output 0.
- **Back-to-back destinations:** a last beat to output 1 is immediately followed by a first beat to output 0.
  - Expect m_valid_out = 3'b010, then 3'b001, in consecutive cycles with no bubble.
- **Reset mid-packet:** assert rst after beat 1 of a 3-beat packet.
  - Expect all outputs = 0 and drop_cnt_out = 0.
  - Expect the next beat to be routed by its own s_id_in.

Source files
------------

// File: rtl/stream_demux_w_qos.sv
// stream_demux_w_qos
// Packet-aware 1-to-N stream router. The merged input stream is split back
// onto STREAM_COUNT output streams. Each packet goes to the output named by
// the id of its first beat. The destination and qos stay locked for the rest
// of the packet. Packets whose id is out of range are discarded.
// A one-entry output register gives one cycle of latency at full throughput.
//
// Optional feature macro: STREAM_DEMUX_DROP_CNT_EN
//   When defined, an 8-bit saturating counter of discarded packets is kept
//   and driven on drop_cnt_out.

module stream_demux_w_qos #(
    parameter int T_DATA_WIDTH = 4,
    parameter int T_QOS__WIDTH = 2,
    parameter int STREAM_COUNT = 3,
    parameter int T_ID___WIDTH = $clog2(STREAM_COUNT)
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic [T_DATA_WIDTH-1:0]                  s_data_in,
    input  logic [T_QOS__WIDTH-1:0]                  s_qos_in,
    input  logic [T_ID___WIDTH-1:0]                  s_id_in,
    input  logic                                     s_last_in,
    input  logic                                     s_valid_in,
    output logic                                     s_ready_out,
    output logic [STREAM_COUNT-1:0][T_DATA_WIDTH-1:0] m_data_out,
    output logic [STREAM_COUNT-1:0][T_QOS__WIDTH-1:0] m_qos_out,
    output logic [STREAM_COUNT-1:0]                  m_last_out,
    output logic [STREAM_COUNT-1:0]                  m_valid_out,
    input  logic [STREAM_COUNT-1:0]                  m_ready_in
`ifdef STREAM_DEMUX_DROP_CNT_EN
    ,
    output logic [7:0]                               drop_cnt_out
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FWD  = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    // Ids at or above this limit name no output and are discarded.
    localparam logic [T_ID___WIDTH:0] ID_LIMIT = STREAM_COUNT[T_ID___WIDTH:0];

    // One-hot valid vector for a destination index.
    function automatic logic [STREAM_COUNT-1:0] dest_onehot(
        input logic [T_ID___WIDTH-1:0] idx
    );
        logic [STREAM_COUNT-1:0] vec;
        vec      = '0;
        vec[idx] = 1'b1;
        return vec;
    endfunction

    state_t                    state_r;
    logic [T_DATA_WIDTH-1:0]   data_r;
    logic [T_QOS__WIDTH-1:0]   qos_r;
    logic [T_ID___WIDTH-1:0]   dest_r;
    logic                      last_r;
    logic [STREAM_COUNT-1:0]   valid_r;

    logic                      full_s;
    logic                      drain_s;
    logic                      id_valid_s;
    logic                      accept_s;
    logic                      load_s;
    logic                      drop_first_s;
    logic [T_ID___WIDTH-1:0]   load_dest_s;
    logic [T_QOS__WIDTH-1:0]   load_qos_s;

    // The register is full whenever one output is being offered a beat.
    assign full_s     = |valid_r;
    assign drain_s    = full_s & m_ready_in[dest_r];
    assign id_valid_s = ({1'b0, s_id_in} < ID_LIMIT);
    assign accept_s   = s_valid_in & s_ready_out;

    // Input ready: discarding states always accept; forwarding needs register room.
    always_comb begin
        s_ready_out = 1'b0;
        if (rst) begin
            s_ready_out = 1'b0;
        end else if (state_r == ST_DROP) begin
            s_ready_out = 1'b1;
        end else if ((state_r == ST_IDLE) && !id_valid_s) begin
            s_ready_out = 1'b1;
        end else begin
            s_ready_out = !full_s || m_ready_in[dest_r];
        end
    end

    // Decide whether an accepted beat loads the register and where it is headed.
    always_comb begin
        load_s       = 1'b0;
        drop_first_s = 1'b0;
        load_dest_s  = dest_r;
        load_qos_s   = qos_r;
        case (state_r)
            ST_IDLE: begin
                if (id_valid_s) begin
                    load_s       = accept_s;
                    drop_first_s = 1'b0;
                end else begin
                    load_s       = 1'b0;
                    drop_first_s = accept_s;
                end
                load_dest_s = s_id_in;
                load_qos_s  = s_qos_in;
            end
            ST_FWD: begin
                load_s      = accept_s;
                load_dest_s = dest_r;
                load_qos_s  = qos_r;
            end
            ST_DROP: begin
                load_s = 1'b0;
            end
            default: begin
                load_s = 1'b0;
            end
        endcase
    end

    // Packet state machine and output register; destination/qos lock on first beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            data_r  <= '0;
            qos_r   <= '0;
            dest_r  <= '0;
            last_r  <= 1'b0;
            valid_r <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        if (s_last_in) begin
                            state_r <= ST_IDLE;
                        end else if (id_valid_s) begin
                            state_r <= ST_FWD;
                        end else begin
                            state_r <= ST_DROP;
                        end
                    end
                end
                ST_FWD: begin
                    if (accept_s && s_last_in) begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_DROP: begin
                    if (accept_s && s_last_in) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase

            if (load_s) begin
                data_r  <= s_data_in;
                last_r  <= s_last_in;
                dest_r  <= load_dest_s;
                qos_r   <= load_qos_s;
                valid_r <= dest_onehot(load_dest_s);
            end else if (drain_s) begin
                valid_r <= '0;
            end
        end
    end

    // Broadcast the held beat to every output; only valid is qualified by dest.
    always_comb begin
        for (int i = 0; i < STREAM_COUNT; i++) begin
            m_data_out[i] = data_r;
            m_qos_out[i]  = qos_r;
            m_last_out[i] = last_r;
        end
        m_valid_out = valid_r;
    end

`ifdef STREAM_DEMUX_DROP_CNT_EN
    logic [7:0] drop_cnt_r;

    // Count discarded packets on their first beat, holding at the maximum.
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt_r <= 8'd0;
        end else if (drop_first_s && (drop_cnt_r != 8'hFF)) begin
            drop_cnt_r <= drop_cnt_r + 8'd1;
        end
    end

    assign drop_cnt_out = drop_cnt_r;
`else
    logic unused_drop_s;
    assign unused_drop_s = drop_first_s;
`endif

endmodule
